rom_sdram_bridge: RTL and testbench

Buffered write bridge between `rom_loader` and the `sdram` controller's toggle-handshake port 0. It accepts word writes from the loader and queues them in a small FIFO. It issues the writes to SDRAM as req/ack toggles, with the bytes swapped for the controller, and throttles the loader through its wait input. The block replaces ad-hoc glue logic and adds overflow detection and end-of-load signalling.

---
 rtl/rom_bridge_pkg.sv | 21 ++
 rtl/bridge_fifo.sv | 57 +++++
 rtl/rom_sdram_bridge.sv | 123 ++++++++++++
 tb/tb_rom_sdram_bridge.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_bridge_pkg.sv
// Shared types and constants for the rom_loader -> SDRAM write bridge.
package rom_bridge_pkg;

  typedef enum logic [1:0] {
    SYNC,
    IDLE,
    BUSY
  } bridge_state_t;

  typedef struct packed {
    logic [23:0] addr;
    logic [15:0] data;
  } bridge_entry_t;

  localparam int unsigned ACK_SYNC_STAGES = 2;

  function automatic logic [15:0] swap_bytes(input logic [15:0] d);
    return {d[7:0], d[15:8]};
  endfunction

endpackage

// File: rtl/bridge_fifo.sv
// Synchronous first-word-fall-through FIFO of bridge entries; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module bridge_fifo
  import rom_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  bridge_entry_t         din_i,
  output bridge_entry_t         dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  bridge_entry_t           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/rom_sdram_bridge.sv
// Buffers rom_loader word writes and replays them on the SDRAM controller's
// req/ack toggle port, with back-pressure, overflow and end-of-load flags.
module rom_sdram_bridge
  import rom_bridge_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 2,
  parameter bit          SWAP       = 1'b1
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic        iloading,
  input  logic        iwr,
  input  logic [24:0] iaddr,
  input  logic [15:0] idata,
  output logic        oload_wait,
  output logic [23:0] osd_addr,
  output logic [15:0] osd_din,
  output logic        osd_req,
  input  logic        isd_ack,
  output logic        odone,
  output logic        ooverflow,
  output logic [23:0] owr_count
);

  localparam logic [DEPTH_LOG2:0] WAIT_LEVEL = {1'b0, {DEPTH_LOG2{1'b1}}};
  localparam logic [1:0]          SYNC_LAST  = 2'(ACK_SYNC_STAGES);

  bridge_state_t       state_q;
  logic [1:0]          sync_cnt_q;
  logic                ack_s1_q, ack_s2_q;
  logic                loading_q, loading_fell_q;
  logic [23:0]         addr_q, wr_count_q;
  logic [15:0]         din_q;
  logic                req_q, done_q, ovf_q;

  bridge_entry_t       head, push_entry;
  logic                fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                push, pop;
  logic                unused_addr0;

  assign unused_addr0 = iaddr[0];
  assign push         = iwr & iloading;
  assign pop          = (state_q == BUSY) && (ack_s2_q == req_q);
  assign push_entry   = '{addr: iaddr[24:1], data: idata};

  bridge_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
    .clk_i   (iclk),
    .rst_ni  (ireset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_entry),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign oload_wait = (fifo_count >= WAIT_LEVEL);
  assign osd_addr   = addr_q;
  assign osd_din    = din_q;
  assign osd_req    = req_q;
  assign odone      = done_q;
  assign ooverflow  = ovf_q;
  assign owr_count  = wr_count_q;

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state_q        <= SYNC;
      sync_cnt_q     <= '0;
      ack_s1_q       <= 1'b0;
      ack_s2_q       <= 1'b0;
      loading_q      <= 1'b0;
      loading_fell_q <= 1'b0;
      addr_q         <= '0;
      din_q          <= '0;
      req_q          <= 1'b0;
      done_q         <= 1'b0;
      ovf_q          <= 1'b0;
      wr_count_q     <= '0;
    end else begin
      ack_s1_q  <= isd_ack;
      ack_s2_q  <= ack_s1_q;
      loading_q <= iloading;
      done_q    <= 1'b0;
      if (push && fifo_full && !pop) ovf_q <= 1'b1;

      unique case (state_q)
        // Wait until ack_s2 carries the real ack level before adopting its parity.
        SYNC: begin
          if (sync_cnt_q == SYNC_LAST) begin
            req_q   <= ack_s2_q;
            state_q <= IDLE;
          end else begin
            sync_cnt_q <= sync_cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (loading_fell_q && fifo_empty) begin
            done_q         <= 1'b1;
            loading_fell_q <= 1'b0;
          end else if (!fifo_empty) begin
            addr_q  <= head.addr;
            din_q   <= SWAP ? swap_bytes(head.data) : head.data;
            req_q   <= ~req_q;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (ack_s2_q == req_q) begin
            wr_count_q <= wr_count_q + 1'b1;
            state_q    <= IDLE;
          end
        end
        default: state_q <= SYNC;
      endcase

      if (iloading && !loading_q)      loading_fell_q <= 1'b0;
      else if (!iloading && loading_q) loading_fell_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_sdram_bridge.sv
// Directed bench for rom_sdram_bridge with a toggle-ack SDRAM responder model.
module tb_rom_sdram_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        loading = 1'b0;
  logic        wr = 1'b0;
  logic [24:0] addr = '0;
  logic [15:0] data = '0;
  logic        ack = 1'b1;
  logic        load_wait, sd_req, done, ovf;
  logic [23:0] sd_addr, wr_count;
  logic [15:0] sd_din;

  int tests = 0;
  int fails = 0;

  bit ack_en = 1'b0;
  int ack_delay = 3;
  int ack_cnt = -1;
  logic [23:0] obs_addr[$];
  logic [15:0] obs_din[$];

  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
    logic [23:0] ea;
    logic [15:0] ed;
  } wr_vec_t;

  typedef struct {
    logic [24:0] a;
    logic [15:0] d;
    logic [23:0] ea;
    logic [15:0] ed;
    logic        ew;
    logic        eo;
  } ov_vec_t;

  wr_vec_t burst[8];
  ov_vec_t ovv[6];

  always #5 clk = ~clk;

  rom_sdram_bridge #(.DEPTH_LOG2(2), .SWAP(1'b1)) dut (
    .iclk       (clk),
    .ireset_n   (rst_n),
    .iloading   (loading),
    .iwr        (wr),
    .iaddr      (addr),
    .idata      (data),
    .oload_wait (load_wait),
    .osd_addr   (sd_addr),
    .osd_din    (sd_din),
    .osd_req    (sd_req),
    .isd_ack    (ack),
    .odone      (done),
    .ooverflow  (ovf),
    .owr_count  (wr_count)
  );

  // SDRAM side: capture each new request, answer it ack_delay cycles later.
  always @(negedge clk) begin
    if (!ack_en || !rst_n) begin
      ack_cnt = -1;
    end else if (ack_cnt < 0) begin
      if (sd_req !== ack) begin
        obs_addr.push_back(sd_addr);
        obs_din.push_back(sd_din);
        ack_cnt = ack_delay;
      end
    end else if (ack_cnt > 1) begin
      ack_cnt = ack_cnt - 1;
    end else begin
      ack = sd_req;
      ack_cnt = -1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_once(input logic [24:0] a, input logic [15:0] d);
    wr = 1'b1;
    addr = a;
    data = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic wait_count(input logic [23:0] target, input int budget, input string name);
    int n = 0;
    while (wr_count !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, wr_count, target);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"},  load_wait, 0);
    check({tag, "_addr"},  sd_addr, 0);
    check({tag, "_din"},   sd_din, 0);
    check({tag, "_req"},   sd_req, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_ovf"},   ovf, 0);
    check({tag, "_count"}, wr_count, 0);
  endtask

  initial begin
    int pop_idx, done_idx, pulses;
    bit wait_seen;

    burst[0] = '{25'h0000010, 16'h1234, 24'h000008, 16'h3412};
    burst[1] = '{25'h0000013, 16'hBEEF, 24'h000009, 16'hEFBE};
    burst[2] = '{25'h1FFFFFE, 16'h00FF, 24'hFFFFFF, 16'hFF00};
    burst[3] = '{25'h1000000, 16'hFFFF, 24'h800000, 16'hFFFF};
    burst[4] = '{25'h0ABCDEF, 16'hC0DE, 24'h55E6F7, 16'hDEC0};
    burst[5] = '{25'h0000002, 16'h8001, 24'h000001, 16'h0180};
    burst[6] = '{25'h1555554, 16'h0F0F, 24'hAAAAAA, 16'h0F0F};
    burst[7] = '{25'h0000000, 16'h7E81, 24'h000000, 16'h817E};

    ovv[0] = '{25'h0000100, 16'hD000, 24'h000080, 16'h00D0, 1'b0, 1'b0};
    ovv[1] = '{25'h0000102, 16'hD001, 24'h000081, 16'h01D0, 1'b0, 1'b0};
    ovv[2] = '{25'h0000104, 16'hD002, 24'h000082, 16'h02D0, 1'b1, 1'b0};
    ovv[3] = '{25'h0000106, 16'hD003, 24'h000083, 16'h03D0, 1'b1, 1'b0};
    ovv[4] = '{25'h0000108, 16'hD004, 24'h000084, 16'h04D0, 1'b1, 1'b1};
    ovv[5] = '{25'h000010A, 16'hD005, 24'h000085, 16'h05D0, 1'b1, 1'b1};

    // Reset with ack high; after SYNC the request line adopts ack parity.
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("sync_req", sd_req, 1);
    ack_en = 1'b1;
    repeat (10) @(negedge clk);
    check("sync_no_write", obs_addr.size(), 0);
    check("sync_count", wr_count, 0);

    // Single write, ack 3 cycles after the toggle.
    ack_delay = 3;
    loading = 1'b1;
    @(negedge clk);
    write_once(25'h000102, 16'hA55A);
    check("single_req_hold", sd_req, 1);
    @(negedge clk);
    check("single_req_toggle", sd_req, 0);
    wait_count(24'd1, 50, "single_count");
    check("single_nreq", obs_addr.size(), 1);
    if (obs_addr.size() >= 1) begin
      check("single_addr", obs_addr[0], 24'h000081);
      check("single_din", obs_din[0], 16'h5AA5);
    end
    check("single_addr_held", sd_addr, 24'h000081);

    // Burst of 8 with a loader that honours oload_wait and a slow ack.
    obs_addr.delete();
    obs_din.delete();
    ack_delay = 10;
    wait_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      int n = 0;
      while (load_wait && n < 200) begin
        wait_seen = 1'b1;
        @(negedge clk);
        n++;
      end
      write_once(burst[i].a, burst[i].d);
      if (load_wait) wait_seen = 1'b1;
    end
    wait_count(24'd9, 600, "burst_count");
    check("burst_nreq", obs_addr.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_addr.size()) begin
        check($sformatf("burst_addr%0d", i), obs_addr[i], burst[i].ea);
        check($sformatf("burst_din%0d", i), obs_din[i], burst[i].ed);
      end
    end
    check("burst_ovf", ovf, 0);
    check("burst_wait_seen", wait_seen, 1);
    check("burst_wait_drained", load_wait, 0);

    // iloading falls with two entries pending: one odone pulse after last pop.
    obs_addr.delete();
    obs_din.delete();
    ack_delay = 3;
    write_once(25'h0000200, 16'h1111);
    write_once(25'h0000202, 16'h2222);
    loading = 1'b0;
    pop_idx = -1;
    done_idx = -1;
    pulses = 0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        pulses++;
        done_idx = k;
      end
      if (pop_idx < 0 && wr_count === 24'd11) pop_idx = k;
    end
    check("done_count", wr_count, 11);
    check("done_pulses", pulses, 1);
    check("done_timing", done_idx, pop_idx + 1);

    // Loader ignores oload_wait, six back-to-back strobes with no ack.
    obs_addr.delete();
    obs_din.delete();
    ack_en = 1'b0;
    loading = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1;
      addr = ovv[i].a;
      data = ovv[i].d;
      @(negedge clk);
      check($sformatf("ovf_wait%0d", i), load_wait, ovv[i].ew);
      check($sformatf("ovf_flag%0d", i), ovf, ovv[i].eo);
    end
    wr = 1'b0;
    @(negedge clk);
    check("ovf_no_ack_count", wr_count, 11);
    ack_en = 1'b1;
    ack_delay = 2;
    wait_count(24'd15, 200, "ovf_drain_count");
    repeat (40) @(negedge clk);
    check("ovf_no_extra", wr_count, 15);
    check("ovf_nreq", obs_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_addr.size()) begin
        check($sformatf("ovf_addr%0d", i), obs_addr[i], ovv[i].ea);
        check($sformatf("ovf_din%0d", i), obs_din[i], ovv[i].ed);
      end
    end
    check("ovf_sticky", ovf, 1);

    // Reset asserted while a write is in flight.
    obs_addr.delete();
    obs_din.delete();
    ack_en = 1'b0;
    write_once(25'h0000300, 16'h3333);
    repeat (3) @(negedge clk);
    check("busy_pending", sd_req ^ ack, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("midreset_parity", sd_req, ack);
    ack_en = 1'b1;
    repeat (20) @(negedge clk);
    check("midreset_no_write", obs_addr.size(), 0);
    check("midreset_count", wr_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
